// File: rtl/senone_normaliser.sv
// Buffers one feature vector of senone scores while the max-finder searches,
// then replays them as (score - best) with index, beam flag and last marker.
module senone_normaliser #(
    parameter int unsigned MAX_SENONES = 1024,
    parameter int unsigned ADDR_W      = 10,
    parameter logic [15:0] BEAM        = 16'd2048
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     new_vector_available,
    input  logic                     new_senone,
    input  logic                     last_senone,
    input  logic signed [15:0]       current_score,
    input  logic signed [15:0]       best_score,
    input  logic                     max_done,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic signed [15:0]       out_score,
    output logic [ADDR_W-1:0]        out_index,
    output logic                     out_active,
    output logic                     out_last,
    output logic                     busy,
    output logic                     overflow
);

    localparam int unsigned SCORE_W = 16;
    localparam int unsigned CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_SENONES);
    localparam logic signed [SCORE_W:0] NEG_BEAM = -$signed({1'b0, BEAM});

    typedef enum logic [1:0] {
        S_COLLECT  = 2'd0,
        S_WAIT_MAX = 2'd1,
        S_DRAIN    = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [CNT_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic signed [SCORE_W-1:0]  best_q, best_d;
    logic                       overflow_q, overflow_d;
    logic                       busy_q, busy_d;

    // read stage: holds the word fetched from the buffer
    logic                       s1_vld_q, s1_vld_d;
    logic [ADDR_W-1:0]          s1_idx_q, s1_idx_d;
    logic                       s1_last_q, s1_last_d;
    logic signed [SCORE_W-1:0]  rd_data_q;

    // output stage
    logic                       out_valid_q, out_valid_d;
    logic signed [SCORE_W-1:0]  out_score_q, out_score_d;
    logic [ADDR_W-1:0]          out_index_q, out_index_d;
    logic                       out_active_q, out_active_d;
    logic                       out_last_q, out_last_d;

    logic                       wr_en;
    logic                       rd_en;
    logic                       out_fire;
    logic                       s1_adv;

    logic [SCORE_W:0]           diff;
    logic signed [SCORE_W-1:0]  sat_score;
    logic                       sat_active;

    logic signed [SCORE_W-1:0]  mem [MAX_SENONES];

    // Normalise the fetched word: 17-bit difference, saturated to 16 bits
    assign diff = {rd_data_q[SCORE_W-1], rd_data_q} - {best_q[SCORE_W-1], best_q};

    // Clamp to the signed 16-bit range and evaluate the beam threshold
    always_comb begin
        sat_score = diff[SCORE_W-1:0];
        if (diff[SCORE_W] != diff[SCORE_W-1]) begin
            sat_score = diff[SCORE_W] ? 16'sh8000 : 16'sh7FFF;
        end
        sat_active = ($signed({sat_score[SCORE_W-1], sat_score}) >= NEG_BEAM);
    end

    // Next-state and datapath control
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        best_d       = best_q;
        overflow_d   = overflow_q;
        s1_vld_d     = s1_vld_q;
        s1_idx_d     = s1_idx_q;
        s1_last_d    = s1_last_q;
        out_valid_d  = out_valid_q;
        out_score_d  = out_score_q;
        out_index_d  = out_index_q;
        out_active_d = out_active_q;
        out_last_d   = out_last_q;
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        out_fire     = out_valid_q & out_ready;
        s1_adv       = s1_vld_q & (~out_valid_q | out_ready);

        if (new_vector_available) begin
            // frame restart wins over everything, including a same-cycle strobe
            state_d     = S_COLLECT;
            count_d     = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            s1_vld_d    = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_COLLECT: begin
                    if (new_senone) begin
                        if (count_q < CNT_MAX) begin
                            wr_en   = 1'b1;
                            count_d = count_q + CNT_W'(1);
                        end else begin
                            overflow_d = 1'b1;
                        end
                        if (last_senone) begin
                            state_d = S_WAIT_MAX;
                        end
                    end
                end

                S_WAIT_MAX: begin
                    if (new_senone) begin
                        overflow_d = 1'b1;
                    end
                    if (max_done) begin
                        best_d   = best_score;
                        rd_ptr_d = '0;
                        s1_vld_d = 1'b0;
                        state_d  = S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    // fetch whenever the read stage is empty or moving on
                    rd_en = (rd_ptr_q < count_q) & (~s1_vld_q | s1_adv);
                    if (rd_en) begin
                        rd_ptr_d  = rd_ptr_q + CNT_W'(1);
                        s1_vld_d  = 1'b1;
                        s1_idx_d  = rd_ptr_q[ADDR_W-1:0];
                        s1_last_d = ((rd_ptr_q + CNT_W'(1)) == count_q);
                    end else if (s1_adv) begin
                        s1_vld_d = 1'b0;
                    end

                    if (s1_adv) begin
                        out_valid_d  = 1'b1;
                        out_score_d  = sat_score;
                        out_index_d  = s1_idx_q;
                        out_active_d = sat_active;
                        out_last_d   = s1_last_q;
                    end else if (out_fire) begin
                        out_valid_d = 1'b0;
                    end

                    if (out_fire && out_last_q) begin
                        state_d     = S_COLLECT;
                        count_d     = '0;
                        overflow_d  = 1'b0;
                        out_valid_d = 1'b0;
                    end

                    if (new_senone) begin
                        overflow_d = 1'b1;
                    end
                end

                default: begin
                    state_d = S_COLLECT;
                end
            endcase
        end

        busy_d = (state_d != S_COLLECT);
    end

    // Control and output registers
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= S_COLLECT;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            best_q       <= '0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
            s1_vld_q     <= 1'b0;
            s1_idx_q     <= '0;
            s1_last_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_score_q  <= '0;
            out_index_q  <= '0;
            out_active_q <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            best_q       <= best_d;
            overflow_q   <= overflow_d;
            busy_q       <= busy_d;
            s1_vld_q     <= s1_vld_d;
            s1_idx_q     <= s1_idx_d;
            s1_last_q    <= s1_last_d;
            out_valid_q  <= out_valid_d;
            out_score_q  <= out_score_d;
            out_index_q  <= out_index_d;
            out_active_q <= out_active_d;
            out_last_q   <= out_last_d;
        end
    end

    // Score buffer with registered read port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[count_q[ADDR_W-1:0]] <= current_score;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_ptr_q[ADDR_W-1:0]];
        end
    end

    assign out_valid  = out_valid_q;
    assign out_score  = out_score_q;
    assign out_index  = out_index_q;
    assign out_active = out_active_q;
    assign out_last   = out_last_q;
    assign busy       = busy_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_senone_normaliser.sv
// Directed bench for senone_normaliser: table-driven frames plus
// hand-written stall, overflow, restart and reset sequences.
module tb_senone_normaliser;

    localparam int unsigned MAX_S = 1024;
    localparam int unsigned AW    = 10;

    logic                 clk = 1'b0;
    logic                 nreset;
    logic                 new_vector_available;
    logic                 new_senone;
    logic                 last_senone;
    logic signed [15:0]   current_score;
    logic signed [15:0]   best_score;
    logic                 max_done;
    logic                 out_ready;
    logic                 out_valid;
    logic signed [15:0]   out_score;
    logic [AW-1:0]        out_index;
    logic                 out_active;
    logic                 out_last;
    logic                 busy;
    logic                 overflow;

    senone_normaliser #(
        .MAX_SENONES(MAX_S),
        .ADDR_W     (AW),
        .BEAM       (16'd2048)
    ) dut (
        .clk                 (clk),
        .nreset              (nreset),
        .new_vector_available(new_vector_available),
        .new_senone          (new_senone),
        .last_senone         (last_senone),
        .current_score       (current_score),
        .best_score          (best_score),
        .max_done            (max_done),
        .out_ready           (out_ready),
        .out_valid           (out_valid),
        .out_score           (out_score),
        .out_index           (out_index),
        .out_active          (out_active),
        .out_last            (out_last),
        .busy                (busy),
        .overflow            (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] score;
        logic signed [15:0] best;
        int                 exp_score;
        int                 exp_active;
    } vec_t;

    vec_t tbl[$];
    int   frame_start[$];
    int   frame_len[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int s, input int b, input int es, input int ea);
        vec_t v;
        v.score      = 16'(s);
        v.best       = 16'(b);
        v.exp_score  = es;
        v.exp_active = ea;
        tbl.push_back(v);
    endtask

    task automatic new_frame();
        frame_start.push_back(tbl.size());
    endtask

    task automatic end_frame();
        frame_len.push_back(tbl.size() - frame_start[frame_start.size()-1]);
    endtask

    // one strobe, called and returning at a falling edge
    task automatic strobe(input logic signed [15:0] s, input bit last);
        new_senone    = 1'b1;
        last_senone   = last;
        current_score = s;
        @(negedge clk);
        new_senone    = 1'b0;
        last_senone   = 1'b0;
    endtask

    // collect, release max_done, drain with out_ready=1 checking every beat
    task automatic run_frame(input int st, input int n, input string tag);
        for (int k = 0; k < n; k++) strobe(tbl[st+k].score, k == n-1);
        chk({tag, "_busy_wait"}, int'(busy), 1);
        chk({tag, "_valid_wait"}, int'(out_valid), 0);
        best_score = tbl[st].best;
        max_done   = 1'b1;
        out_ready  = 1'b1;
        @(negedge clk);
        max_done = 1'b0;
        chk({tag, "_lat1"}, int'(out_valid), 0);
        @(negedge clk);
        chk({tag, "_lat2"}, int'(out_valid), 0);
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            chk({tag, "_valid"}, int'(out_valid), 1);
            chk({tag, "_score"}, int'(out_score), tbl[st+k].exp_score);
            chk({tag, "_index"}, int'(out_index), k);
            chk({tag, "_active"}, int'(out_active), tbl[st+k].exp_active);
            chk({tag, "_last"}, int'(out_last), (k == n-1) ? 1 : 0);
            @(negedge clk);
        end
        chk({tag, "_valid_end"}, int'(out_valid), 0);
        chk({tag, "_busy_end"}, int'(busy), 0);
    endtask

    initial begin
        int f4, f6, f7;
        int got, stalls, beats, bad, last_idx, ov_drain;
        int t4_exp[3];

        nreset               = 1'b0;
        new_vector_available = 1'b0;
        new_senone           = 1'b0;
        last_senone          = 1'b0;
        current_score        = '0;
        best_score           = '0;
        max_done             = 1'b0;
        out_ready            = 1'b1;

        // frame 0: basic normalisation
        new_frame();
        add(100, 300, -200, 1); add(-50, 300, -350, 1);
        add(300, 300, 0, 1);    add(300, 300, 0, 1);
        end_frame();
        // frame 1: beam edge
        new_frame();
        add(0, 0, 0, 1); add(-2048, 0, -2048, 1); add(-2049, 0, -2049, 0);
        end_frame();
        // frame 2: negative saturation
        new_frame(); add(-32768, 32767, -32768, 0); end_frame();
        // frame 3: positive saturation
        new_frame(); add(32767, -32768, 32767, 1); end_frame();
        // frame 4: single senone equal to best
        new_frame(); add(1234, 1234, 0, 1); end_frame();
        f4 = 5;
        // frame 5: restart frame after abort
        new_frame(); add(5, 7, -2, 1); add(7, 7, 0, 1); end_frame();
        // frame 6: recovery after mid-run reset
        new_frame(); add(8, 8, 0, 1); end_frame();
        f6 = 5; f7 = 6;

        #12;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_score", int'(out_score), 0);
        chk("rst_index", int'(out_index), 0);
        chk("rst_active", int'(out_active), 0);
        chk("rst_last", int'(out_last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overflow", int'(overflow), 0);
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);

        for (int f = 0; f < f4; f++) begin
            run_frame(frame_start[f], frame_len[f], $sformatf("frame%0d", f));
        end

        // stalls: out_ready cycles 1,0,0,1
        t4_exp[0] = -20; t4_exp[1] = -10; t4_exp[2] = 0;
        strobe(16'sd10, 1'b0); strobe(16'sd20, 1'b0); strobe(16'sd30, 1'b1);
        best_score = 16'sd30;
        max_done   = 1'b1;
        @(negedge clk);
        max_done = 1'b0;
        got = 0; stalls = 0;
        for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
            out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            if (out_valid) begin
                chk("stall_score", int'(out_score), t4_exp[got]);
                chk("stall_index", int'(out_index), got);
                chk("stall_last", int'(out_last), (got == 2) ? 1 : 0);
                if (out_ready) got++;
                else stalls++;
            end
            @(negedge clk);
        end
        chk("stall_beats", got, 3);
        chk("stall_seen", int'(stalls > 0), 1);
        chk("stall_no_dup", int'(out_valid), 0);
        out_ready = 1'b1;

        // overflow: MAX+3 strobes
        for (int i = 0; i < MAX_S + 3; i++) strobe(16'(i), i == MAX_S + 2);
        chk("ovf_flag", int'(overflow), 1);
        best_score = 16'(MAX_S - 1);
        max_done   = 1'b1;
        @(negedge clk);
        max_done = 1'b0;
        beats = 0; bad = 0; last_idx = -1; ov_drain = 0;
        for (int cyc = 0; cyc < MAX_S + 50; cyc++) begin
            if (out_valid) begin
                if (beats == 0) ov_drain = int'(overflow);
                if (int'(out_index) != beats) bad++;
                if (int'(out_score) != beats - int'(MAX_S - 1)) bad++;
                if (out_active !== 1'b1) bad++;
                if (out_last) last_idx = int'(out_index);
                beats++;
            end else if (beats > 0) begin
                break;
            end
            @(negedge clk);
        end
        chk("ovf_beats", beats, MAX_S);
        chk("ovf_bad_beats", bad, 0);
        chk("ovf_last_idx", last_idx, MAX_S - 1);
        chk("ovf_held_in_drain", ov_drain, 1);
        chk("ovf_cleared", int'(overflow), 0);

        // abort mid-drain, then a fresh two-senone frame
        strobe(16'sd1, 1'b0); strobe(16'sd2, 1'b0); strobe(16'sd3, 1'b1);
        best_score = 16'sd3;
        max_done   = 1'b1;
        out_ready  = 1'b0;
        @(negedge clk);
        max_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_valid_before", int'(out_valid), 1);
        chk("abort_score_before", int'(out_score), -2);
        strobe(16'sd77, 1'b0);
        chk("drain_drop_ovf", int'(overflow), 1);
        chk("drain_drop_hold", int'(out_index), 0);
        new_vector_available = 1'b1;
        new_senone           = 1'b1;
        current_score        = 16'sd999;
        @(negedge clk);
        new_vector_available = 1'b0;
        new_senone           = 1'b0;
        chk("abort_valid_drop", int'(out_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ovf_clear", int'(overflow), 0);
        run_frame(frame_start[f6], frame_len[f6], "restart");

        // asynchronous reset while a beat is stalled
        strobe(16'sd4, 1'b0); strobe(16'sd4, 1'b1);
        best_score = 16'sd4;
        max_done   = 1'b1;
        out_ready  = 1'b0;
        @(negedge clk);
        max_done = 1'b0;
        strobe(16'sd9, 1'b0);
        @(negedge clk);
        chk("mreset_valid_before", int'(out_valid), 1);
        #2 nreset = 1'b0;
        #1;
        chk("mreset_valid", int'(out_valid), 0);
        chk("mreset_busy", int'(busy), 0);
        chk("mreset_ovf", int'(overflow), 0);
        chk("mreset_index", int'(out_index), 0);
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        run_frame(frame_start[f7], frame_len[f7], "recover");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
